// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-address control block.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } pc_state_e;

  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Sign-extended B-type immediate. Bit 0 is always zero.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/static_branch_predictor.sv
// Static backward-taken predictor for conditional branches.
// The prediction is dropped when the target is not a legal fetch address.
module static_branch_predictor
  import pc_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic is_bwd_branch;
  logic tgt_legal;
  // Register fields do not affect the static prediction.
  logic unused_fields;

  assign target_o      = pc_i + b_imm(instr_i);
  assign is_bwd_branch = (instr_i[6:0] == OPC_BRANCH) && instr_i[31];
  assign tgt_legal     = (target_o[1:0] == 2'b00) && ({1'b0, target_o} < PC_LIMIT);
  assign taken_o       = valid_i && is_bwd_branch && tgt_legal;
  assign unused_fields = ^instr_i[24:12];

endmodule

// File: rtl/pc_control.sv
// Fetch-address control: sequential fetch with wrap, stall refetch,
// redirect flush, halt/resume and a sticky error for illegal targets.
// Optional backward-branch prediction is enabled by BRANCH_PREDICT_EN.
module pc_control
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  input  logic [31:0] fetch_instr,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        misalign_err,
  output logic        halted
);

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;

  logic        rdr_legal;
  logic [31:0] pc_inc;
  logic [31:0] pc_seq;

  assign rdr_legal = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < PC_LIMIT);
  assign pc_inc    = pc_q + 32'd4;
  assign pc_seq    = ({1'b0, pc_inc} == PC_LIMIT) ? 32'd0 : pc_inc;

`ifdef BRANCH_PREDICT_EN
  // pend_q marks that the next sequential fetch is a predicted target.
  logic        pred_q, pred_d;
  logic        pend_q, pend_d;
  logic        pred_taken;
  logic [31:0] pred_target;

  static_branch_predictor #(
    .MEM_WORDS (MEM_WORDS)
  ) u_bp (
    .valid_i  (if_valid_q),
    .instr_i  (fetch_instr),
    .pc_i     (if_pc_q),
    .taken_o  (pred_taken),
    .target_o (pred_target)
  );

  assign if_pred_taken = pred_q;
`else
  logic unused_fetch;
  assign unused_fetch  = ^fetch_instr;
  assign if_pred_taken = 1'b0;
`endif

  // During a stall the held instruction is re-read so fetch_instr stays put.
  assign pc           = (stall && if_valid_q) ? if_pc_q : pc_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign halted       = (state_q == ST_HALT);
  assign misalign_err = (state_q == ST_ERR);

  // Next-state and next-fetch selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
`ifdef BRANCH_PREDICT_EN
    pred_d     = pred_q;
    pend_d     = pend_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
`ifdef BRANCH_PREDICT_EN
          pred_d     = 1'b0;
          pend_d     = 1'b0;
`endif
          if (rdr_legal) begin
            pc_d = redirect_pc;
            if (halt_req) state_d = ST_HALT;
          end else begin
            state_d = ST_ERR;
          end
        end else if (halt_req) begin
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
`ifdef BRANCH_PREDICT_EN
          pred_d     = 1'b0;
          pend_d     = 1'b0;
`endif
        end else if (!stall) begin
`ifdef BRANCH_PREDICT_EN
          if (pred_taken) begin
            // Fall-through fetch is dropped; target gets flagged next step.
            pc_d       = pred_target;
            if_valid_d = 1'b0;
            pred_d     = 1'b0;
            pend_d     = 1'b1;
          end else begin
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_seq;
            pred_d     = pend_q;
            pend_d     = 1'b0;
          end
`else
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_seq;
`endif
        end
      end
      ST_HALT: begin
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          if (rdr_legal) pc_d = redirect_pc;
          else           state_d = ST_ERR;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d    = ST_ERR;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and fetch registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'd0;
      if_valid_q <= 1'b0;
`ifdef BRANCH_PREDICT_EN
      pred_q     <= 1'b0;
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
`ifdef BRANCH_PREDICT_EN
      pred_q     <= pred_d;
      pend_q     <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_pc_control;

  localparam int          MW  = 256;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] fetch_instr = 32'd0;
  logic [31:0] pc, if_pc;
  logic        if_valid, if_pred_taken, misalign_err, halted;

  pc_control #(.RESET_PC(RPC), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
    .fetch_instr(fetch_instr), .pc(pc), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .misalign_err(misalign_err), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, one cycle behind pc.
  logic [31:0] mem [MW];
  always @(posedge clk) fetch_instr <= mem[pc[9:2]];

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;  // 0 run, 1 halt, 2 error
  logic [31:0] m_pc, m_ifpc;
  bit          m_val, m_pred, m_pend;
`ifdef BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < MW * 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = RPC; m_ifpc = 0; m_val = 0; m_pred = 0; m_pend = 0;
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        if (legal(redirect_pc)) m_pc = redirect_pc;
        else m_mode = 2;
      end else if (resume) m_mode = 0;
    end else if (m_mode == 0) begin
      if (redirect_valid) begin
        m_val = 0; m_pred = 0; m_pend = 0;
        if (!legal(redirect_pc)) m_mode = 2;
        else begin
          m_pc = redirect_pc;
          if (halt_req) m_mode = 1;
        end
      end else if (halt_req) begin
        m_mode = 1; m_val = 0; m_pred = 0; m_pend = 0;
      end else if (!stall) begin
        logic [31:0] ins, tgt;
        logic signed [12:0] im;
        int off;
        ins = mem[m_ifpc[9:2]];
        im  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        off = int'(im);
        tgt = m_ifpc + 32'(off);
        if (PRED && m_val && ins[6:0] == 7'h63 && ins[31] && legal(tgt)) begin
          m_pc = tgt; m_val = 0; m_pred = 0; m_pend = 1;
        end else begin
          m_ifpc = m_pc; m_val = 1; m_pred = m_pend; m_pend = 0;
          m_pc = (m_pc + 4 == MW * 4) ? 32'd0 : m_pc + 4;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, (stall && m_val) ? m_ifpc : m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_val});
      if (m_val) chk("if_pc", if_pc, m_ifpc);
      chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_pred});
      chk("halted", {31'd0, halted}, {31'd0, m_mode == 1});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mode == 2});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; halt_req = 0; resume = 0; redirect_pc = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[6:0] == 7'h63) w[31] = 1'b0;
      mem[i] = w;
    end
    tick(); chk_en = 1'b1;
    tick();
    // reset state
    chk("rst_pc", pc, RPC);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
    rst = 0;

    // sequential wrap
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("wrap_pc", if_pc, 32'(i * 4));
      chk("wrap_valid", {31'd0, if_valid}, 32'd1);
    end
    tick(); chk("wrap_zero", if_pc, 32'd0);

    // stall at 0x10
    for (int i = 0; i < 4; i++) tick();
    chk("pre_stall_ifpc", if_pc, 32'h10);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h10);
      chk("stall_ifpc", if_pc, 32'h10);
      chk("stall_instr", fetch_instr, mem[4]);
    end
    stall = 0; tick(); chk("post_stall_ifpc", if_pc, 32'h14);

    // redirect to 0x40 at 0x8
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rdr_ifpc", if_pc, 32'h8);
    redirect_valid = 1; redirect_pc = 32'h40; tick(); idle();
    chk("rdr_flush", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rdr_ifpc", if_pc, 32'h40);
    chk("rdr_valid", {31'd0, if_valid}, 32'd1);

    // misaligned redirect -> sticky error
    redirect_valid = 1; redirect_pc = 32'h42; tick(); idle();
    chk("err_mis", {31'd0, misalign_err}, 32'd1);
    resume = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) tick();
    idle();
    chk("err_sticky", {31'd0, misalign_err}, 32'd1);
    chk("err_valid", {31'd0, if_valid}, 32'd0);
    do_reset();
    chk("err_cleared", {31'd0, misalign_err}, 32'd0);
    tick();
    redirect_valid = 1; redirect_pc = 32'h400; tick(); idle();
    chk("err_range", {31'd0, misalign_err}, 32'd1);

    // halt with redirect, then resume
    do_reset();
    tick(); tick();
    halt_req = 1; redirect_valid = 1; redirect_pc = 32'h80; tick(); idle();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, if_valid}, 32'd0);
    stall = 1; tick(); stall = 0;
    chk("halt_hold", {31'd0, halted}, 32'd1);
    resume = 1; tick(); resume = 0;
    chk("resume_run", {31'd0, halted}, 32'd0);
    tick();
    chk("resume_ifpc", if_pc, 32'h80);
    chk("resume_valid", {31'd0, if_valid}, 32'd1);

    // asynchronous reset overrides pending halt and stall
    halt_req = 1; stall = 1; #2 rst = 1; #1;
    chk("arst_pc", pc, RPC);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    tick(); idle(); rst = 0;
    tick();
    chk("first_fetch", if_pc, RPC);
    chk("first_valid", {31'd0, if_valid}, 32'd1);

`ifdef BRANCH_PREDICT_EN
    // backward branch at 0x20 predicted to 0x1C
    rst = 1; mem[8] = 32'hFE000EE3; tick(); tick(); rst = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("bp_at20", if_pc, 32'h20);
    tick();
    chk("bp_flush", {31'd0, if_valid}, 32'd0);
    tick();
    chk("bp_ifpc", if_pc, 32'h1C);
    chk("bp_flag", {31'd0, if_pred_taken}, 32'd1);
`endif

    // randomized phase
    do_reset();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = 7'h63; w[31] = 1'b1;
      mem[$urandom_range(0, MW - 1)] = w;
    end
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      stall = ($urandom_range(0, 4) == 0);
      halt_req = ($urandom_range(0, 29) == 0);
      resume = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if (r < 5) redirect_pc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1023)) | 32'd2
                                                            : 32'h400 + 32'($urandom_range(0, 255) * 4);
      else redirect_pc = 32'($urandom_range(0, MW - 1) * 4);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1; #1;
        tick(); rst = 0;
      end else tick();
    end
    idle();
    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 256: instruction memory depth in 32-bit words; legal PC range is 0 .. MEM_WORDS*4-4.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port stall, input, 1: downstream hold request.
REQ-006 SHALL have port redirect_valid, input, 1: taken branch or jump resolved downstream.
REQ-007 SHALL have port redirect_pc, input, 32: redirect target.
REQ-008 SHALL have port halt_req, input, 1: stop fetching.
REQ-009 SHALL have port resume, input, 1: leave HALT.
REQ-010 SHALL have port fetch_instr, input, 32: instruction memory output, registered, one-cycle latency from pc.
REQ-011 SHALL have port pc, output, 32: fetch address to the instruction memory.
REQ-012 SHALL have port if_valid, output, 1: fetch_instr holds a valid, correct-path instruction this cycle.
REQ-013 SHALL have port if_pc, output, 32: address of the instruction on fetch_instr.
REQ-014 SHALL have port if_pred_taken, output, 1: the fetch_instr instruction was predicted taken.
REQ-015 SHALL have port misalign_err, output, 1: sticky fetch-address error.
REQ-016 SHALL have port halted, output, 1: FSM is in HALT.

Function
REQ-017 SHALL implement FSM states RUN, HALT and ERR; halted=1 only in HALT, and misalign_err=1 only in ERR.
REQ-018 SHALL drive pc combinationally: if_pc when stall=1 and if_valid=1, otherwise the internal register pc_reg (this re-fetches the held instruction during a stall).
REQ-019 SHALL apply RUN priority per edge: redirect_valid, then halt_req, then stall, then sequential.
REQ-020 Sequential step in RUN SHALL do: if_pc<=pc_reg, if_valid<=1, pc_reg<=pc_reg+4; pc_reg SHALL wrap to 0 when pc_reg+4 equals MEM_WORDS*4.
REQ-021 Stall in RUN SHALL hold pc_reg, if_pc, if_valid and if_pred_taken.
REQ-022 A legal redirect (redirect_pc[1:0]=0 and redirect_pc < MEM_WORDS*4) SHALL do: pc_reg<=redirect_pc, if_valid<=0 (flush the wrong-path fetch). Latency: the target instruction appears with if_valid=1 two edges after the redirect edge.
REQ-023 An illegal redirect in any state except ERR SHALL cause: ERR, if_valid<=0, pc_reg held.
REQ-024 halt_req in RUN SHALL cause: HALT, if_valid<=0, pc_reg held. Simultaneous legal redirect plus halt_req SHALL cause: HALT with pc_reg=redirect_pc.
REQ-025 In HALT: a legal redirect SHALL update pc_reg and the FSM SHALL remain in HALT. resume SHALL cause RUN, with the next fetch at pc_reg. if_valid SHALL stay 0.
REQ-026 ERR SHALL be left only by rst; in ERR, if_valid=0 and all other inputs SHALL be ignored.
REQ-027 stall SHALL be ignored in HALT and ERR.

Reset
REQ-028 On rst (asynchronous): pc_reg=RESET_PC, if_pc=0, if_valid=0, if_pred_taken=0, state=RUN.
REQ-029 rst asserted mid-operation SHALL override every pending redirect, halt or stall immediately.
REQ-030 The first edge after rst deasserts SHALL fetch RESET_PC, and if_valid=1 SHALL follow at that edge.

Configuration
REQ-031 With BRANCH_PREDICT_EN defined, on a RUN sequential step the block SHALL predict taken when: if_valid=1, fetch_instr[6:0]=7'b1100011 and fetch_instr[31]=1 (backward branch).
REQ-032 On a taken prediction: pc_reg<=if_pc+B-immediate, if_valid<=0 (drop the fall-through fetch), and the flag marks the target instruction with if_pred_taken=1. A target outside the legal range SHALL suppress the prediction.
REQ-033 Without BRANCH_PREDICT_EN, if_pred_taken SHALL be constant 0 and no prediction logic SHALL exist.

Structure
REQ-034 Package pc_pkg SHALL hold: the state enum, OPC_BRANCH=7'b1100011, the default RESET_PC, and the B-immediate extraction function.
REQ-035 Prediction SHALL be a combinational sub-module, static_branch_predictor, instantiated only under BRANCH_PREDICT_EN.

Verification
REQ-036 Sequential wrap: release rst, 256 unstalled cycles -> if_pc 0,4,...,0x3FC then 0; if_valid=1 from the first edge.
REQ-037 Stall: stall=1 for 3 cycles while if_pc=0x10 -> pc=0x10 and if_pc=0x10 held; fetch_instr unchanged; after release, if_pc=0x14.
REQ-038 Redirect: redirect to 0x40 at if_pc=0x8 -> next cycle if_valid=0; following cycle if_pc=0x40, if_valid=1.
REQ-039 Error: redirect_pc=0x42, then redirect_pc=0x400 after rst -> misalign_err=1 sticky, if_valid=0, until rst.
REQ-040 Halt: halt_req plus redirect 0x80 -> halted=1, if_valid=0; resume -> if_pc=0x80 two edges later.
REQ-041 With BRANCH_PREDICT_EN: instruction 0xFE000EE3 (beq x0,x0,-4) at 0x20 -> if_pc=0x1C with if_pred_taken=1; the 0x24 fetch is flushed.
